// File: rtl/async_rr_arbiter.sv
// Round-robin arbiter sharing one req/ack functional unit among num_clients requesters.
// Optional REQ-state watchdog enabled by defining ASYNC_ARB_TIMEOUT_EN.
module async_rr_arbiter #(
  parameter int num_clients    = 4,
  parameter int data_width     = 32,
  parameter int id_width       = 2,
  parameter int timeout_cycles = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [num_clients-1:0]            cli_req,
  output logic [num_clients-1:0]            cli_ack,
  input  logic [num_clients*data_width-1:0] cli_din,
  output logic [data_width-1:0]             cli_dout,
  output logic [id_width-1:0]               cli_id,
  output logic                              res_req,
  input  logic                              res_ack,
  output logic [data_width-1:0]             res_din,
  input  logic [data_width-1:0]             res_dout,
  output logic                              busy,
  output logic                              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2} state_t;

  state_t                 state, state_n;
  logic [id_width-1:0]    ptr, ptr_n, gnt, gnt_n, cli_id_n, ptr_adv;
  logic [num_clients-1:0] cli_ack_n, gnt_onehot;
  logic [data_width-1:0]  cli_dout_n, res_din_n, pick_din;
  logic                   res_req_n, any_req;
  logic [id_width-1:0]    pick;
  int                     best_dist;
`ifdef ASYNC_ARB_TIMEOUT_EN
  logic [15:0]            wdog, wdog_n;
  logic                   err_q, err_n;
`endif

  // Candidate with the smallest wrapped distance from ptr wins.
  always_comb begin
    any_req   = 1'b0;
    pick      = '0;
    pick_din  = '0;
    best_dist = num_clients;
    for (int i = 0; i < num_clients; i++) begin
      if (cli_req[i] && (((i + num_clients - int'(ptr)) % num_clients) < best_dist)) begin
        best_dist = (i + num_clients - int'(ptr)) % num_clients;
        any_req   = 1'b1;
        pick      = id_width'(i);
        pick_din  = cli_din[i*data_width +: data_width];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < num_clients; i++) begin
      gnt_onehot[i] = (int'(gnt) == i);
    end
    ptr_adv = id_width'((int'(gnt) + 1) % num_clients);
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    gnt_n      = gnt;
    cli_id_n   = cli_id;
    res_din_n  = res_din;
    res_req_n  = res_req;
    cli_ack_n  = '0;
    cli_dout_n = cli_dout;
`ifdef ASYNC_ARB_TIMEOUT_EN
    wdog_n     = wdog;
    err_n      = err_q;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_n     = pick;
          cli_id_n  = pick;
          res_din_n = pick_din;
          res_req_n = 1'b1;
          state_n   = REQ;
`ifdef ASYNC_ARB_TIMEOUT_EN
          wdog_n    = '0;
`endif
        end
      end
      REQ: begin
        if (res_ack) begin
          cli_dout_n = res_dout;
          cli_ack_n  = gnt_onehot;
          res_req_n  = 1'b0;
          ptr_n      = ptr_adv;
          state_n    = ACK;
        end
`ifdef ASYNC_ARB_TIMEOUT_EN
        else if (wdog == 16'(timeout_cycles - 1)) begin
          // Unit never answered: complete the client with an all-ones marker.
          cli_dout_n = '1;
          cli_ack_n  = gnt_onehot;
          res_req_n  = 1'b0;
          ptr_n      = ptr_adv;
          err_n      = 1'b1;
          state_n    = ACK;
        end else begin
          wdog_n = wdog + 16'd1;
        end
`endif
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      cli_id   <= '0;
      res_din  <= '0;
      res_req  <= 1'b0;
      cli_ack  <= '0;
      cli_dout <= '0;
`ifdef ASYNC_ARB_TIMEOUT_EN
      wdog     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gnt      <= gnt_n;
      cli_id   <= cli_id_n;
      res_din  <= res_din_n;
      res_req  <= res_req_n;
      cli_ack  <= cli_ack_n;
      cli_dout <= cli_dout_n;
`ifdef ASYNC_ARB_TIMEOUT_EN
      wdog     <= wdog_n;
      err_q    <= err_n;
`endif
    end
  end

  assign busy = (state != IDLE);
`ifdef ASYNC_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_async_rr_arbiter.sv
// Scoreboard bench for async_rr_arbiter: randomized clients and shared-unit model,
// grant order predicted from the round-robin rule, responses checked by a monitor.
module tb_async_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
`ifdef ASYNC_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif
  localparam int PH_RUN = 0, PH_FAIR = 1, PH_SPUR = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    cli_req;
  logic [N-1:0]    cli_ack;
  logic [N*DW-1:0] cli_din;
  logic [DW-1:0]   cli_dout;
  logic [IW-1:0]   cli_id;
  logic            res_req;
  logic            res_ack;
  logic [DW-1:0]   res_din;
  logic [DW-1:0]   res_dout;
  logic            busy;
  logic            err;

  async_rr_arbiter #(
    .num_clients(N), .data_width(DW), .id_width(IW), .timeout_cycles(TO)
  ) dut (
    .clk(clk), .rst(rst), .cli_req(cli_req), .cli_ack(cli_ack), .cli_din(cli_din),
    .cli_dout(cli_dout), .cli_id(cli_id), .res_req(res_req), .res_ack(res_ack),
    .res_din(res_din), .res_dout(res_dout), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dout;
    logic          err;
    int            lat;
  } exp_t;

  exp_t rq[$];
  int   gq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   phase   = PH_RUN;

  // Stimulus knobs
  logic [N-1:0]  mask;
  int            req_pct;
  int            ack_mode;   // 0 immediate, 1 random delay, 2 stall, 3 stall expecting timeout
  bit            spur_en;
  bit            use_fixed;
  logic [DW-1:0] fixed_din, fixed_dout;
  bit            unit_busy;
  int            wait_cnt;
  bit            tb_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic e, input int lat);
    exp_t x;
    x.dout = d;
    x.err  = e;
    x.lat  = lat;
    rq.push_back(x);
  endtask

  // One cycle of client and shared-unit behaviour, driven on the falling edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (cli_req[i] && cli_ack[i]) begin
        cli_req[i] = 1'b0;
      end else if (!cli_req[i] && mask[i] && ($urandom_range(99) < req_pct)) begin
        cli_req[i] = 1'b1;
        cli_din[i*DW +: DW] = use_fixed ? fixed_din : $urandom;
      end
    end
    if (res_ack) begin
      res_ack = 1'b0;
    end else if (res_req) begin
      if (!unit_busy) begin
        unit_busy = 1'b1;
        wait_cnt  = (ack_mode == 1) ? int'($urandom_range(3)) : 0;
        if (ack_mode == 3) begin
          tb_err = 1'b1;
          push_exp('1, 1'b1, TO);
        end
      end
      if (ack_mode <= 1) begin
        if (wait_cnt == 0) begin
          res_ack  = 1'b1;
          res_dout = use_fixed ? fixed_dout : $urandom;
          push_exp(res_dout, tb_err, 0);
        end else begin
          wait_cnt--;
        end
      end
    end else begin
      unit_busy = 1'b0;
      if (spur_en && ($urandom_range(1) == 1)) res_ack = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst       = 1'b0;
    res_ack   = 1'b0;
    unit_busy = 1'b0;
    tb_err    = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: predicts grants from the round-robin rule and pops expected responses.
  initial begin
    logic          prev_req = 1'b0;
    logic [DW-1:0] last_dout = '0;
    logic [IW-1:0] last_id = '0;
    int            mptr = 0, gcyc = 0, cyc = 0, last_ack_cyc = 0, last_ack_phase = -1;
    int            pick, g;
    exp_t          e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        check("rst_ctrl", {cli_ack, res_req, busy, cli_id, err}, '0);
        check("rst_cli_dout", cli_dout, '0);
        check("rst_res_din", res_din, '0);
        rq.delete();
        gq.delete();
        mptr = 0;
        prev_req = 1'b0;
        last_dout = '0;
        last_id = '0;
        last_ack_phase = -1;
      end else begin
        if (res_req && !prev_req) begin
          pick = -1;
          for (int k = 0; k < N; k++) begin
            if (pick < 0 && cli_req[(mptr + k) % N]) pick = (mptr + k) % N;
          end
          if (pick < 0) begin
            fail("grant_without_request");
          end else begin
            check("grant_id", cli_id, pick);
            check("grant_operand", res_din, cli_din[pick*DW +: DW]);
            check("grant_busy", busy, 1);
            gq.push_back(pick);
            mptr    = (pick + 1) % N;
            gcyc    = cyc;
            last_id = IW'(pick);
          end
        end else begin
          check("cli_id_hold", cli_id, last_id);
        end
        if (cli_ack != '0) begin
          check("ack_onehot", $onehot0(cli_ack), 1);
          if (gq.size() == 0 || rq.size() == 0) begin
            fail("unexpected_ack");
          end else begin
            g = gq.pop_front();
            e = rq.pop_front();
            check("ack_vec", cli_ack, 1 << g);
            check("ack_dout", cli_dout, e.dout);
            check("ack_id", cli_id, g);
            check("ack_err", err, e.err);
            if (e.lat > 0) check("timeout_latency", cyc - gcyc, e.lat);
            if (phase == PH_FAIR && last_ack_phase == PH_FAIR)
              check("fair_gap", cyc - last_ack_cyc, 3);
            last_dout      = e.dout;
            last_ack_cyc   = cyc;
            last_ack_phase = phase;
          end
        end else begin
          check("cli_dout_hold", cli_dout, last_dout);
        end
        if (phase == PH_SPUR) check("spur_busy", busy, 0);
        prev_req = res_req;
      end
    end
  end

  initial begin
    cli_req = '0; cli_din = '0; res_ack = 1'b0; res_dout = '0;
    mask = '0; req_pct = 0; ack_mode = 0; spur_en = 0; use_fixed = 0;
    fixed_din = '0; fixed_dout = '0; unit_busy = 0; wait_cnt = 0; tb_err = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Single client, fixed operand/result
    use_fixed = 1; fixed_din = 32'h05; fixed_dout = 32'h2A;
    mask = 4'b0001; req_pct = 100; ack_mode = 0;
    step();
    mask = '0;
    repeat (8) step();
    use_fixed = 0;

    // Fairness from a fresh pointer, all clients held high
    do_reset(2);
    phase = PH_FAIR; mask = '1; req_pct = 100; ack_mode = 0;
    repeat (18) step();
    phase = PH_RUN; mask = '0;
    repeat (14) step();

    // Pointer wrap: grant 3 alone, then 1 and 3 together
    mask = 4'b1000;
    step();
    mask = '0;
    repeat (4) step();
    mask = 4'b1010;
    step();
    mask = '0;
    repeat (10) step();

    // Spurious unit acks while idle
    phase = PH_SPUR; spur_en = 1;
    repeat (10) step();
    spur_en = 0; phase = PH_RUN;
    step();

    // Reset while waiting on the unit
    mask = 4'b0100; ack_mode = 2;
    step();
    mask = '0;
    repeat (3) step();
    do_reset(2);
    ack_mode = 0;
    repeat (10) step();

    // Randomized traffic
    ack_mode = 1; mask = '1; req_pct = 30; spur_en = 1;
    repeat (600) step();
    mask = '0; spur_en = 0;
    repeat (20) step();

`ifdef ASYNC_ARB_TIMEOUT_EN
    // Unit never answers, then a good transaction keeps err set
    ack_mode = 3; mask = 4'b0100; req_pct = 100;
    step();
    mask = '0;
    repeat (14) step();
    ack_mode = 0; mask = 4'b0010;
    step();
    mask = '0;
    repeat (8) step();
`endif

    ack_mode = 0;
    repeat (20) step();
    check("resp_queue_drained", rq.size(), 0);
    check("grant_queue_drained", gq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
